// File: rtl/aes_pkg.sv
// AES-128 shared definitions: GF(2^8) arithmetic, S-boxes, byte permutations, key schedule step.
// Shared between the ECB encrypt and decrypt cores.
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic [2:0] {StIdle, StKeyExp, StInit, StRound, StFinal} state_e;

  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gmul(gmul(a, a), a);
    x7   = gmul(gmul(x3, x3), a);
    x15  = gmul(gmul(x7, x7), a);
    x31  = gmul(gmul(x15, x15), a);
    x63  = gmul(gmul(x31, x31), a);
    x127 = gmul(gmul(x63, x63), a);
    return gmul(x127, x127);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = gf_inv(b);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  // Byte k of the state sits at bits [127-8k -: 8], k = 4*col + row.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/ecb_dec_if.sv
// Start/done handshake and 128-bit data/key buses of the ECB decrypt core.
interface ecb_dec_if;
  logic         start;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic         done;
  logic         busy;

  modport master (output start, ciphertext, key, input plaintext, done, busy);
  modport slave  (input start, ciphertext, key, output plaintext, done, busy);
endinterface

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round; last_round skips InvMixColumns for the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk,
  input  logic         last_round,
  output logic [127:0] state_out
);

  logic [127:0] t, mc;
  logic [7:0]   a0, a1, a2, a3;

  always_comb begin
    t = inv_shift_rows(state_in);
    for (int i = 0; i < 16; i++) begin
      t[127-8*i -: 8] = inv_sbox(t[127-8*i -: 8]);
    end
    t  = t ^ rk;
    mc = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = t[127-32*c -: 8];
      a1 = t[119-32*c -: 8];
      a2 = t[111-32*c -: 8];
      a3 = t[103-32*c -: 8];
      mc[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      mc[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      mc[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      mc[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    state_out = last_round ? t : mc;
  end

endmodule

// File: rtl/ecb_dec.sv
// Iterative AES-128 ECB decrypt core: on-chip key expansion, then one inverse round per clock.
// Optional ECB_DEC_KEY_CACHE_EN skips key expansion when the key matches the last expanded one.
module ecb_dec
  import aes_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  ecb_dec_if.slave bus
);

  state_e       state_q, state_d;
  logic [3:0]   ctr_q, ctr_d, ctr_m1;
  logic [127:0] rk_q [NR+1];
  logic [127:0] rk_d [NR+1];
  logic [127:0] data_q, data_d, pt_q, pt_d;
  logic         done_q, done_d, busy_q, busy_d;
  logic [127:0] round_out;

`ifdef ECB_DEC_KEY_CACHE_EN
  logic key_valid_q, key_valid_d;
`endif

  assign ctr_m1 = ctr_q - 4'd1;

  // ctr is 0 in FINAL, so rk_q[ctr_q] selects rk0 there as well.
  aes_inv_round u_inv_round (
    .state_in   (data_q),
    .rk         (rk_q[ctr_q]),
    .last_round (state_q == StFinal),
    .state_out  (round_out)
  );

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    rk_d    = rk_q;
    data_d  = data_q;
    pt_d    = pt_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
`ifdef ECB_DEC_KEY_CACHE_EN
    key_valid_d = key_valid_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          rk_d[0] = bus.key;
          data_d  = bus.ciphertext;
          busy_d  = 1'b1;
          ctr_d   = 4'd1;
          state_d = StKeyExp;
`ifdef ECB_DEC_KEY_CACHE_EN
          // rk0 doubles as the stored key; rk1..rk10 still hold its schedule.
          if (key_valid_q && (bus.key == rk_q[0])) state_d = StInit;
          key_valid_d = 1'b1;
`endif
        end
      end
      StKeyExp: begin
        rk_d[ctr_q] = expand_key(rk_q[ctr_m1], RCON[ctr_q]);
        ctr_d       = ctr_q + 4'd1;
        if (ctr_q == 4'(NR)) state_d = StInit;
      end
      StInit: begin
        data_d  = data_q ^ rk_q[NR];
        ctr_d   = 4'(NR - 1);
        state_d = StRound;
      end
      StRound: begin
        data_d = round_out;
        ctr_d  = ctr_m1;
        if (ctr_q == 4'd1) state_d = StFinal;
      end
      StFinal: begin
        pt_d    = round_out;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ctr_q   <= '0;
      rk_q    <= '{default: '0};
      data_q  <= '0;
      pt_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ECB_DEC_KEY_CACHE_EN
      key_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      rk_q    <= rk_d;
      data_q  <= data_d;
      pt_q    <= pt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef ECB_DEC_KEY_CACHE_EN
      key_valid_q <= key_valid_d;
`endif
    end
  end

  assign bus.plaintext = pt_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ecb_dec.sv
// Bench for ecb_dec: FIPS-197 vectors, handshake timing, reset abort and a random round trip
// against a byte-level AES-128 encryption model.
module tb_ecb_dec;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  ecb_dec_if bus ();

  ecb_dec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic [7:0]   sb [256];
  logic [127:0] rnd_key [64];
  logic [127:0] rnd_pt  [64];
  logic [127:0] rnd_ct  [64];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // S-box from its definition: brute-force inverse, then the affine map bit by bit.
  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 16; j++) st[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int j = 0; j < 16; j++) st[j] = sb[st[j]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) tmp[4*c+rw] = st[4*((c+rw)%4)+rw];
      for (int c = 0; c < 4; c++) begin
        a0 = tmp[4*c]; a1 = tmp[4*c+1]; a2 = tmp[4*c+2]; a3 = tmp[4*c+3];
        if (r < 10) begin
          tmp[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          tmp[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          tmp[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          tmp[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int j = 0; j < 16; j++) st[j] = tmp[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) o[127-8*j -: 8] = st[j];
    return o;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One block: start for one edge, scramble inputs, then time done/busy and check the result.
  task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] c,
                           input logic [127:0] exp_pt, input int exp_lat, input int pulse_at);
    int cyc, busy_cnt, extra;
    bus.key        = k;
    bus.ciphertext = c;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.key        = rnd128();
    bus.ciphertext = rnd128();
    cyc      = 0;
    busy_cnt = 0;
    while (!bus.done && cyc < 40) begin
      busy_cnt += int'(bus.busy);
      @(posedge clk); #1;
      cyc++;
      bus.start = (cyc == pulse_at);
    end
    bus.start = 1'b0;
    check_int({tag, " latency"}, cyc, exp_lat);
    check_int({tag, " busy cycles"}, busy_cnt, exp_lat);
    check({tag, " plaintext"}, bus.plaintext, exp_pt);
    @(posedge clk); #1;
    check({tag, " done pulse width"}, 128'(bus.done), 128'(0));
    check({tag, " plaintext hold"}, bus.plaintext, exp_pt);
    if (pulse_at > 0) begin
      extra = 0;
      repeat (24) begin
        @(posedge clk); #1;
        extra += int'(bus.done);
      end
      check_int({tag, " extra done"}, extra, 0);
      check({tag, " plaintext unchanged"}, bus.plaintext, exp_pt);
    end
  endtask

  initial begin
    int cyc;
    bus.start      = 1'b0;
    bus.key        = '0;
    bus.ciphertext = '0;
    build_sbox();
    for (int i = 0; i < 64; i++) begin
      rnd_key[i] = rnd128();
      rnd_pt[i]  = rnd128();
      rnd_ct[i]  = aes_enc(rnd_key[i], rnd_pt[i]);
    end

    #3;
    check("reset plaintext", bus.plaintext, 128'(0));
    check("reset done", 128'(bus.done), 128'(0));
    check("reset busy", 128'(bus.busy), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_block("c1", K_C1, CT_C1, PT_C1, 21, 0);
    run_block("zero key", '0, CT_Z, '0, 21, 5);
    run_block("app b", K_B, CT_B, PT_B, 21, 0);

    // Abort a C.1 block after 12 edges with an asynchronous reset between edges.
    bus.key        = K_C1;
    bus.ciphertext = CT_C1;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    check("busy before abort", 128'(bus.busy), 128'(1));
    rst = 1'b1;
    #1;
    check("abort done", 128'(bus.done), 128'(0));
    check("abort busy", 128'(bus.busy), 128'(0));
    check("abort plaintext", bus.plaintext, 128'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_block("c1 after abort", K_C1, CT_C1, PT_C1, 21, 0);

    // Random round trip with start held high: blocks back to back.
    bus.key        = rnd_key[0];
    bus.ciphertext = rnd_ct[0];
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.key        = rnd_key[1];
    bus.ciphertext = rnd_ct[1];
    for (int b = 0; b < 64; b++) begin
      cyc = (b == 0) ? 0 : 1;
      while (!bus.done && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
      end
      check_int($sformatf("stream %0d interval", b), cyc, (b == 0) ? 21 : 22);
      check($sformatf("stream %0d plaintext", b), bus.plaintext, rnd_pt[b]);
      @(posedge clk); #1;
      if (b + 2 < 64) begin
        bus.key        = rnd_key[b+2];
        bus.ciphertext = rnd_ct[b+2];
      end
      if (b + 1 == 63) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    repeat (30) @(posedge clk);
    #1;

`ifdef ECB_DEC_KEY_CACHE_EN
    run_block("cache first", K_C1, CT_C1, PT_C1, 21, 0);
    run_block("cache hit", K_C1, CT_C1, PT_C1, 11, 0);
    run_block("cache miss", K_B, CT_B, PT_B, 21, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
